// File: rtl/vec_alu_pipe.sv
// Vector ALU: LANES independent N-bit signed lanes, two-stage valid/ready pipeline.
// S1 registers the operand bundle, S2 computes per-lane results/flags and registers them.

// Per-lane datapath: one op on one N-bit signed lane, with NZCV flags and masking.
module vec_alu_lane #(
  parameter int N = 16
) (
  input  logic [3:0]   op_i,
  input  logic         en_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] res_o,
  output logic [3:0]   flg_o
);
  localparam int SH_W = $clog2(N);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3,
                         OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7,
                         OP_MUL = 4'd8,  OP_MIN = 4'd9,  OP_MAX = 4'd10, OP_ADDS = 4'd11,
                         OP_SUBS = 4'd12;

  logic [N:0]      sum, dif;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    sat, r;
  logic [SH_W-1:0] sh;
  logic            add_ov, sub_ov, mul_ov, lt, c, v, ill;

  // Shared adder/subtractor/multiplier feeding an opcode mux, then flag and mask logic.
  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, b_i};
    dif    = {1'b0, a_i} - {1'b0, b_i};
    add_ov = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
    sub_ov = (a_i[N-1] != b_i[N-1]) && (dif[N-1] != a_i[N-1]);
    // Overflow direction always follows the sign of a for both add and subtract.
    sat    = a_i[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    // Sign-extended operands make the low 2N bits of the product the signed product.
    prod   = {{N{a_i[N-1]}}, a_i} * {{N{b_i[N-1]}}, b_i};
    mul_ov = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
    lt     = $signed(a_i) < $signed(b_i);
    sh     = b_i[SH_W-1:0];
    r      = '0;
    c      = 1'b0;
    v      = 1'b0;
    ill    = 1'b0;
    case (op_i)
      OP_ADD:  begin r = sum[N-1:0]; c = sum[N]; v = add_ov; end
      OP_SUB:  begin r = dif[N-1:0]; c = dif[N]; v = sub_ov; end
      OP_AND:  r = a_i & b_i;
      OP_OR:   r = a_i | b_i;
      OP_XOR:  r = a_i ^ b_i;
      OP_SLL:  r = a_i << sh;
      OP_SRL:  r = a_i >> sh;
      OP_SRA:  r = $signed(a_i) >>> sh;
      OP_MUL:  begin r = prod[N-1:0]; v = mul_ov; end
      OP_MIN:  r = lt ? a_i : b_i;
      OP_MAX:  r = lt ? b_i : a_i;
      OP_ADDS: begin r = add_ov ? sat : sum[N-1:0]; c = sum[N]; v = add_ov; end
      OP_SUBS: begin r = sub_ov ? sat : dif[N-1:0]; c = dif[N]; v = sub_ov; end
      default: ill = 1'b1;
    endcase
    res_o = r;
    flg_o = {r[N-1], (r == '0), c, v};
    if (!en_i || ill) begin
      res_o = '0;
      flg_o = 4'b0000;
    end
  end
endmodule

module vec_alu_pipe #(
  parameter int N     = 16,
  parameter int LANES = 4,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ctrl,
  input  logic [LANES-1:0]   mask,
  input  logic [TAG_W-1:0]   tag,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] result,
  output logic [LANES*4-1:0] flags,
  output logic [TAG_W-1:0]   out_tag,
  output logic               illegal
);
  logic                      s1_valid_q, s2_valid_q, s2_load;
  logic [3:0]                s1_ctrl_q;
  logic [LANES-1:0]          s1_mask_q;
  logic [TAG_W-1:0]          s1_tag_q, tag_q;
  logic [LANES-1:0][N-1:0]   s1_a_q, s1_b_q, res_d, res_q;
  logic [LANES-1:0][3:0]     flg_d, flg_q;
  logic                      ill_d, ill_q;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign ill_d    = s1_ctrl_q > 4'd12;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vec_alu_lane #(.N(N)) u_lane (
      .op_i (s1_ctrl_q),
      .en_i (s1_mask_q[gi]),
      .a_i  (s1_a_q[gi]),
      .b_i  (s1_b_q[gi]),
      .res_o(res_d[gi]),
      .flg_o(flg_d[gi])
    );
  end

  // S1: capture the operand bundle whenever the stage is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_mask_q  <= '0;
      s1_tag_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_ctrl_q <= ctrl;
        s1_mask_q <= mask;
        s1_tag_q  <= tag;
        s1_a_q    <= a;
        s1_b_q    <= b;
      end
    end
  end

  // S2: register computed lanes; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
      tag_q      <= '0;
      ill_q      <= 1'b0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
        tag_q <= s1_tag_q;
        ill_q <= ill_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign flags     = flg_q;
  assign out_tag   = tag_q;
  assign illegal   = ill_q;
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe: driver pushes expected responses on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_vec_alu_pipe;
  localparam int N = 16, LANES = 4, TAG_W = 5;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      res;
    logic [15:0]      flg;
    logic             ill;
  } exp_t;

  logic               clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic               in_ready, out_valid, illegal;
  logic [3:0]         ctrl = '0;
  logic [LANES-1:0]   mask = '0;
  logic [TAG_W-1:0]   tag = '0, out_tag;
  logic [LANES*N-1:0] a = '0, b = '0, result;
  logic [LANES*4-1:0] flags;

  int   n_chk = 0, n_fail = 0;
  exp_t sb[$];

  vec_alu_pipe #(.N(N), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .mask(mask), .tag(tag), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .out_tag(out_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] p4(input int l0, input int l1, input int l2, input int l3);
    logic [15:0] x0, x1, x2, x3;
    x0 = l0[15:0]; x1 = l1[15:0]; x2 = l2[15:0]; x3 = l3[15:0];
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [15:0] f4(input logic [3:0] f0, input logic [3:0] f1,
                                     input logic [3:0] f2, input logic [3:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  // Drive one op starting just after a posedge; push its expectation on the accepting edge.
  task automatic send(input logic [3:0] op, input logic [3:0] m, input logic [TAG_W-1:0] t,
                      input logic [63:0] aa, input logic [63:0] bb,
                      input logic [63:0] er, input logic [15:0] ef, input logic ei);
    exp_t e;
    bit   acc = 0;
    int   n = 0;
    e.tag = t; e.res = er; e.flg = ef; e.ill = ei;
    in_valid = 1'b1; ctrl = op; mask = m; tag = t; a = aa; b = bb;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb.push_back(e);
        acc = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 64'(t), 64'h0);
    in_valid = 1'b0;
  endtask

  // Monitor: compare each output transfer with the queue head; check stall stability.
  logic             held_vld = 1'b0;
  logic [63:0]      held_res;
  logic [15:0]      held_flg;
  logic [TAG_W-1:0] held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sb.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        chk("stall_valid", 64'(out_valid), 64'h1);
        chk("stall_result", result, held_res);
        chk("stall_flags", 64'(flags), 64'(held_flg));
        chk("stall_tag", 64'(out_tag), 64'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_tag", 64'(out_tag), 64'h1f1f);
        end else begin
          e = sb.pop_front();
          chk("tag", 64'(out_tag), 64'(e.tag));
          chk("result", result, e.res);
          chk("flags", 64'(flags), 64'(e.flg));
          chk("illegal", 64'(illegal), 64'(e.ill));
        end
      end
      held_vld = out_valid && !out_ready;
      held_res = result; held_flg = flags; held_tag = out_tag;
    end
  end

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
    chk("rst_tag", 64'(out_tag), 64'h0);
    chk("rst_illegal", 64'(illegal), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 ADD, with latency check on an empty pipe
    send(4'b0000, 4'hF, 5'd1, p4(4857, -5, 32767, 0), p4(7465, 2, 1, 0),
         p4(12322, -3, -32768, 0), f4(4'b0000, 4'b1000, 4'b1001, 4'b0100), 1'b0);
    @(negedge clk); chk("lat_t1_cyc1", 64'(out_valid), 64'h0);
    @(negedge clk); chk("lat_t1_cyc2", 64'(out_valid), 64'h1);
    @(posedge clk); #1;

    // T2..T4 plus logic/shift/minmax, back-to-back
    send(4'b0001, 4'hF, 5'd2, p4(7465, -5, 10, 2), p4(4857, 2, 10, 4),
         p4(2608, -7, 0, -2), f4(4'b0000, 4'b1000, 4'b0100, 4'b1010), 1'b0);
    send(4'b1011, 4'hF, 5'd3, p4(32767, 5, -32768, 0), p4(1, 6, -1, 0),
         p4(32767, 11, -32768, 0), f4(4'b0001, 4'b0000, 4'b1011, 4'b0100), 1'b0);
    send(4'b1100, 4'hF, 5'd4, p4(-32768, 32767, 100, 3), p4(1, -1, 30, 3),
         p4(-32768, 32767, 70, 0), f4(4'b1001, 4'b0011, 4'b0000, 4'b0100), 1'b0);
    send(4'b1000, 4'hF, 5'd5, p4(300, -3, 7, 0), p4(300, 4, -2, 5),
         p4(24464, -12, -14, 0), f4(4'b0001, 4'b1000, 4'b1000, 4'b0100), 1'b0);
    send(4'b0000, 4'b0101, 5'd6, p4(1, 2, 3, 4), p4(10, 20, 30, 40),
         p4(11, 0, 33, 0), f4(4'b0000, 4'b0000, 4'b0000, 4'b0000), 1'b0);
    send(4'b1111, 4'hF, 5'd7, p4(1, 2, 3, 4), p4(1, 2, 3, 4),
         64'h0, 16'h0, 1'b1);
    send(4'b0111, 4'hF, 5'd8, p4(-16, -16, 16, 1), p4(2, 18, 1, 15),
         p4(-4, -4, 8, 0), f4(4'b1000, 4'b1000, 4'b0000, 4'b0100), 1'b0);
    send(4'b0101, 4'hF, 5'd9, p4(1, 3, -1, 'h4000), p4(4, 'h11, 15, 1),
         p4(16, 6, -32768, -32768), f4(4'b0000, 4'b0000, 4'b1000, 4'b1000), 1'b0);
    send(4'b0110, 4'hF, 5'd10, p4(-1, 256, 0, 7), p4(12, 4, 3, 0),
         p4(15, 16, 0, 7), f4(4'b0000, 4'b0000, 4'b0100, 4'b0000), 1'b0);
    send(4'b1001, 4'hF, 5'd11, p4(-5, 10, 0, -32768), p4(3, -10, 0, 32767),
         p4(-5, -10, 0, -32768), f4(4'b1000, 4'b1000, 4'b0100, 4'b1000), 1'b0);
    send(4'b1010, 4'hF, 5'd12, p4(-5, 10, 0, -32768), p4(3, -10, 0, 32767),
         p4(3, 10, 0, 32767), f4(4'b0000, 4'b0000, 4'b0100, 4'b0000), 1'b0);
    send(4'b0010, 4'hF, 5'd13, p4('hF0F0, 'h1234, 0, 'hFFFF), p4('hFF00, 'h00FF, 'hFFFF, 'h8001),
         p4('hF000, 'h0034, 0, 'h8001), f4(4'b1000, 4'b0000, 4'b0100, 4'b1000), 1'b0);
    send(4'b0011, 4'hF, 5'd14, p4('hF0F0, 'h1234, 0, 'hFFFF), p4('hFF00, 'h00FF, 'hFFFF, 'h8001),
         p4('hFFF0, 'h12FF, 'hFFFF, 'hFFFF), f4(4'b1000, 4'b0000, 4'b1000, 4'b1000), 1'b0);
    send(4'b0100, 4'hF, 5'd15, p4('hF0F0, 'h1234, 0, 'hFFFF), p4('hFF00, 'h00FF, 'hFFFF, 'h8001),
         p4('h0FF0, 'h12CB, 'hFFFF, 'h7FFE), f4(4'b0000, 4'b0000, 4'b1000, 4'b0000), 1'b0);
    repeat (4) @(posedge clk); #1;

    // T5 stream of 8 with a 3-cycle consumer stall mid-stream
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(4'b0000, 4'hF, 5'(15 + k), p4(100 * k, 100 * k, 100 * k, 100 * k),
               p4(k, k, k, k), p4(101 * k, 101 * k, 101 * k, 101 * k), 16'h0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t5_in_ready_full", 64'(in_ready), 64'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("t5_drained", 64'(sb.size()), 64'h0);

    // T6a flush with two ops in flight and a third offered on the flush cycle
    out_ready = 1'b0;
    send(4'b0000, 4'hF, 5'd26, p4(1, 1, 1, 1), p4(1, 1, 1, 1), p4(2, 2, 2, 2), 16'h0, 1'b0);
    send(4'b0000, 4'hF, 5'd27, p4(2, 2, 2, 2), p4(1, 1, 1, 1), p4(3, 3, 3, 3), 16'h0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; tag = 5'd28;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b0001, 4'hF, 5'd29, p4(9, 9, 9, 9), p4(4, 4, 4, 4), p4(5, 5, 5, 5), 16'h0, 1'b0);
    @(negedge clk); chk("lat_flush_cyc1", 64'(out_valid), 64'h0);
    @(negedge clk); chk("lat_flush_cyc2", 64'(out_valid), 64'h1);
    @(posedge clk); #1;

    // T6b asynchronous reset pulse with ops in flight
    out_ready = 1'b0;
    send(4'b0000, 4'hF, 5'd30, p4(5, 5, 5, 5), p4(5, 5, 5, 5), p4(10, 10, 10, 10), 16'h0, 1'b0);
    send(4'b0000, 4'hF, 5'd31, p4(6, 6, 6, 6), p4(5, 5, 5, 5), p4(11, 11, 11, 11), 16'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_tag", 64'(out_tag), 64'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b1000, 4'hF, 5'd0, p4(-7, 6, 0, 256), p4(3, -6, 9, 256),
         p4(-21, -36, 0, 0), f4(4'b1000, 4'b1000, 4'b0100, 4'b0101), 1'b0);
    @(negedge clk); chk("lat_rst_cyc1", 64'(out_valid), 64'h0);
    @(negedge clk); chk("lat_rst_cyc2", 64'(out_valid), 64'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
